// File: rtl/ts_gen_mlane_if.sv
// ts_gen_mlane_if: command, backpressure and per-lane ordered-set bus between the LTSSM side and ts_gen_mlane.
interface ts_gen_mlane_if #(
   parameter int LANES = 4,
   parameter int TS_W  = 128,
   parameter int CNT_W = 12
) ();
   logic [7:0]            ts_info;
   logic [TS_W-1:0]       ts;
   logic [CNT_W-1:0]      ts_tgt;
   logic                  ts_update;
   logic                  ts_stop;
   logic                  speed;
   logic [LANES-1:0]      lane_en;
   logic                  ts_tx_fifo_full;
   logic                  ts_valid;
   logic [LANES*TS_W-1:0] ts_out;
   logic [7:0]            ts_info_out;
   logic [CNT_W-1:0]      ts_sent_cnt;
   logic                  to_tsa_ts_sent_enough;
   logic                  ts_busy;
   modport master (
      output ts_info, ts, ts_tgt, ts_update, ts_stop, speed, lane_en, ts_tx_fifo_full,
      input  ts_valid, ts_out, ts_info_out, ts_sent_cnt, to_tsa_ts_sent_enough, ts_busy
   );
   modport slave (
      input  ts_info, ts, ts_tgt, ts_update, ts_stop, speed, lane_en, ts_tx_fifo_full,
      output ts_valid, ts_out, ts_info_out, ts_sent_cnt, to_tsa_ts_sent_enough, ts_busy
   );
endinterface

// File: rtl/ts_gen_mlane.sv
// ts_gen_mlane: multi-lane TS ordered-set generator with per-speed interval, stall and shadowed commands.
// Optional TS_GEN_LANE_NUM_EN: stamp the lane index into symbol 2 of each enabled lane (unless PAD).
module ts_gen_mlane #(
   parameter int LANES   = 4,
   parameter int TS_W    = 128,
   parameter int CNT_W   = 12,
   parameter int INTV_G1 = 64,
   parameter int INTV_G2 = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   ts_gen_mlane_if.slave bus
);
   localparam int IW = $clog2(INTV_G1 > INTV_G2 ? INTV_G1 : INTV_G2);
   typedef enum logic [1:0] {IDLE, SEND, STALL} state_e;
   state_e                state_q;
   logic [IW-1:0]         cnt_q;
   logic [TS_W-1:0]       act_ts_q, sh_ts_q;
   logic [7:0]            act_info_q, sh_info_q, info_out_q;
   logic [CNT_W-1:0]      act_tgt_q, sh_tgt_q, sent_cnt_q;
   logic                  pend_q, valid_q, enough_q;
   logic [LANES*TS_W-1:0] out_q, lanes_d;
   logic [TS_W-1:0]       src_ts;
   logic [7:0]            src_info;
   logic [IW-1:0]         reload;
   logic                  due, emit, apply;
   // A pending shadow supplies the content of the emission that applies it.
   assign src_ts   = pend_q ? sh_ts_q : act_ts_q;
   assign src_info = pend_q ? sh_info_q : act_info_q;
   assign due      = (state_q == SEND && cnt_q == '0) || state_q == STALL;
   assign emit     = due && !bus.ts_tx_fifo_full;
   assign apply    = emit && pend_q;
   assign reload   = bus.speed ? IW'(INTV_G2 - 1) : IW'(INTV_G1 - 1);
   always_comb begin
      lanes_d = '0;
      for (int n = 0; n < LANES; n++) begin
         if (bus.lane_en[n]) begin
            lanes_d[n*TS_W +: TS_W] = src_ts;
`ifdef TS_GEN_LANE_NUM_EN
            if (src_ts[23:16] != 8'hF7) lanes_d[n*TS_W+16 +: 8] = 8'(n);
`endif
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         act_ts_q   <= '0;
         sh_ts_q    <= '0;
         act_info_q <= '0;
         sh_info_q  <= '0;
         info_out_q <= '0;
         act_tgt_q  <= '0;
         sh_tgt_q   <= '0;
         sent_cnt_q <= '0;
         pend_q     <= 1'b0;
         valid_q    <= 1'b0;
         enough_q   <= 1'b0;
         out_q      <= '0;
      end else begin
         valid_q <= emit;
         if (emit) begin
            out_q      <= lanes_d;
            info_out_q <= src_info;
            cnt_q      <= reload;
            sent_cnt_q <= pend_q ? CNT_W'(1) : (&sent_cnt_q ? sent_cnt_q : sent_cnt_q + 1'b1);
         end else if (state_q == SEND) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (apply) begin
            act_ts_q   <= sh_ts_q;
            act_info_q <= sh_info_q;
            act_tgt_q  <= sh_tgt_q;
         end
         if (state_q != IDLE) enough_q <= apply ? 1'b0 : sent_cnt_q >= act_tgt_q;
         case (state_q)
            IDLE: begin
               if (bus.ts_update && !bus.ts_stop) begin
                  state_q    <= SEND;
                  act_ts_q   <= bus.ts;
                  act_info_q <= bus.ts_info;
                  act_tgt_q  <= bus.ts_tgt;
                  sent_cnt_q <= '0;
                  enough_q   <= 1'b0;
                  cnt_q      <= '0;
               end
            end
            default: begin
               if (bus.ts_stop) begin
                  state_q <= IDLE;
                  pend_q  <= 1'b0;
               end else begin
                  state_q <= emit ? SEND : (due ? STALL : SEND);
                  pend_q  <= bus.ts_update || (pend_q && !emit);
                  if (bus.ts_update) begin
                     sh_ts_q   <= bus.ts;
                     sh_info_q <= bus.ts_info;
                     sh_tgt_q  <= bus.ts_tgt;
                  end
               end
            end
         endcase
      end
   end
   assign bus.ts_valid              = valid_q;
   assign bus.ts_out                = out_q;
   assign bus.ts_info_out           = info_out_q;
   assign bus.ts_sent_cnt           = sent_cnt_q;
   assign bus.to_tsa_ts_sent_enough = enough_q;
   assign bus.ts_busy               = state_q != IDLE;
endmodule

// File: tb/tb_ts_gen_mlane.sv
// tb_ts_gen_mlane: directed scenarios for ts_gen_mlane with hand-derived strobe times and contents.
module tb_ts_gen_mlane;
   localparam logic [127:0] T1 = 128'h4A4A4A4A_4A4A4A4A_4A4A4A4A_7E0211BC;
   localparam logic [127:0] T2 = 128'h45454545_45454545_45454545_1F0533BC;
   localparam logic [127:0] T0 = 128'h4A4A4A4A_4A4A4A4A_4A4A4A4A_0F0000BC;
   localparam logic [127:0] TF = 128'h4A4A4A4A_4A4A4A4A_4A4A4A4A_0FF7F7BC;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   ts_gen_mlane_if #(.LANES(4), .TS_W(128), .CNT_W(12)) bus ();
   ts_gen_mlane #(.LANES(4), .TS_W(128), .CNT_W(12), .INTV_G1(64), .INTV_G2(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   // Expected four-lane word for a template and enable mask.
   function automatic logic [511:0] exp_out(input logic [127:0] t, input logic [3:0] en);
      logic [127:0] l;
      exp_out = '0;
      for (int n = 0; n < 4; n++) begin
         l = t;
`ifdef TS_GEN_LANE_NUM_EN
         if (t[23:16] != 8'hF7) l[23:16] = 8'(n);
`endif
         if (en[n]) exp_out[n*128 +: 128] = l;
      end
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic start(input logic [7:0] info, input logic [127:0] t, input logic [11:0] tgt,
                        input logic spd, input logic [3:0] en);
      bus.ts_info = info; bus.ts = t; bus.ts_tgt = tgt; bus.speed = spd; bus.lane_en = en;
      bus.ts_update = 1'b1;
      tick();
      bus.ts_update = 1'b0;
   endtask
   task automatic stop();
      bus.ts_stop = 1'b1;
      tick();
      bus.ts_stop = 1'b0;
   endtask
   task automatic test_reset();
      checks += 6;
      if (bus.ts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", bus.ts_valid); end
      if (bus.ts_out !== '0) begin errors++; $display("FAIL reset_out got %0h exp 0", bus.ts_out); end
      if (bus.ts_info_out !== 8'h00) begin errors++; $display("FAIL reset_info got %0h exp 0", bus.ts_info_out); end
      if (bus.ts_sent_cnt !== 12'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.ts_sent_cnt); end
      if (bus.to_tsa_ts_sent_enough !== 1'b0) begin errors++; $display("FAIL reset_enough got %0h exp 0", bus.to_tsa_ts_sent_enough); end
      if (bus.ts_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", bus.ts_busy); end
   endtask
   task automatic test_gen1();
      int n = 0;
      start(8'h11, T1, 12'd4, 1'b0, 4'hF);
      checks++;
      if (bus.ts_busy !== 1'b1) begin errors++; $display("FAIL g1_busy got %0h exp 1", bus.ts_busy); end
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (bus.ts_valid === 1'b1) begin
            checks += 3;
            if (k != 1 + 64*n) begin errors++; $display("FAIL g1_time got %0d exp %0d", k, 1 + 64*n); end
            if (bus.ts_sent_cnt !== 12'(n + 1)) begin errors++; $display("FAIL g1_cnt got %0d exp %0d", bus.ts_sent_cnt, n + 1); end
            if (bus.ts_info_out !== 8'h11) begin errors++; $display("FAIL g1_info got %0h exp 11", bus.ts_info_out); end
            if (n == 0) begin
               checks++;
               if (bus.ts_out !== exp_out(T1, 4'hF)) begin errors++; $display("FAIL g1_out got %0h exp %0h", bus.ts_out, exp_out(T1, 4'hF)); end
            end
            n++;
         end
         if (k == 193) begin
            checks++;
            if (bus.to_tsa_ts_sent_enough !== 1'b0) begin errors++; $display("FAIL g1_enough_early got 1 exp 0"); end
         end
         if (k == 194) begin
            checks++;
            if (bus.to_tsa_ts_sent_enough !== 1'b1) begin errors++; $display("FAIL g1_enough got %0h exp 1", bus.to_tsa_ts_sent_enough); end
         end
      end
      checks++;
      if (n != 4) begin errors++; $display("FAIL g1_strobes got %0d exp 4", n); end
      stop();
   endtask
   task automatic test_stall();
      int n = 0;
      int exp_t[3] = '{1, 41, 73};
      start(8'h12, T1, 12'd8, 1'b1, 4'hF);
      for (int k = 1; k <= 80; k++) begin
         bus.ts_tx_fifo_full = (k >= 30 && k <= 40);
         tick();
         if (bus.ts_valid === 1'b1) begin
            checks += 2;
            if (n > 2 || k != exp_t[n > 2 ? 2 : n]) begin errors++; $display("FAIL stall_time got %0d strobe %0d", k, n); end
            if (bus.ts_sent_cnt !== 12'(n + 1)) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", bus.ts_sent_cnt, n + 1); end
            n++;
         end
         if (k == 35) begin
            checks++;
            if (bus.ts_busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %0h exp 1", bus.ts_busy); end
         end
      end
      bus.ts_tx_fifo_full = 1'b0;
      checks++;
      if (n != 3) begin errors++; $display("FAIL stall_strobes got %0d exp 3", n); end
      stop();
   endtask
   task automatic test_update_mid();
      int n = 0;
      start(8'h10, T1, 12'd1, 1'b0, 4'hF);
      for (int k = 1; k <= 130; k++) begin
         bus.ts_update = (k == 20 || k == 30);
         bus.ts_info = (k < 30) ? 8'h20 : 8'h21;
         bus.ts = T2;
         bus.ts_tgt = 12'd2;
         tick();
         if (k == 10) begin
            checks++;
            if (bus.to_tsa_ts_sent_enough !== 1'b1) begin errors++; $display("FAIL upd_enough_old got %0h exp 1", bus.to_tsa_ts_sent_enough); end
         end
         if (bus.ts_valid === 1'b1 && k == 65) begin
            checks += 4;
            if (bus.ts_info_out !== 8'h21) begin errors++; $display("FAIL upd_info got %0h exp 21", bus.ts_info_out); end
            if (bus.ts_sent_cnt !== 12'd1) begin errors++; $display("FAIL upd_cnt got %0d exp 1", bus.ts_sent_cnt); end
            if (bus.to_tsa_ts_sent_enough !== 1'b0) begin errors++; $display("FAIL upd_enough got %0h exp 0", bus.to_tsa_ts_sent_enough); end
            if (bus.ts_out !== exp_out(T2, 4'hF)) begin errors++; $display("FAIL upd_out got %0h exp %0h", bus.ts_out, exp_out(T2, 4'hF)); end
         end
         if (bus.ts_valid === 1'b1) n++;
         if (k == 130) begin
            checks += 2;
            if (bus.ts_sent_cnt !== 12'd2) begin errors++; $display("FAIL upd_cnt2 got %0d exp 2", bus.ts_sent_cnt); end
            if (bus.to_tsa_ts_sent_enough !== 1'b1) begin errors++; $display("FAIL upd_enough2 got %0h exp 1", bus.to_tsa_ts_sent_enough); end
         end
      end
      bus.ts_update = 1'b0;
      checks++;
      if (n != 3) begin errors++; $display("FAIL upd_strobes got %0d exp 3", n); end
      stop();
   endtask
   task automatic test_stop();
      int n = 0;
      start(8'h13, T1, 12'd8, 1'b1, 4'hF);
      for (int k = 1; k <= 33; k++) begin
         bus.ts_stop = (k == 33);
         tick();
      end
      bus.ts_stop = 1'b0;
      checks += 3;
      if (bus.ts_valid !== 1'b1) begin errors++; $display("FAIL stop_valid got %0h exp 1", bus.ts_valid); end
      if (bus.ts_busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %0h exp 0", bus.ts_busy); end
      if (bus.ts_sent_cnt !== 12'd2) begin errors++; $display("FAIL stop_cnt got %0d exp 2", bus.ts_sent_cnt); end
      for (int k = 0; k < 40; k++) begin
         tick();
         if (bus.ts_valid === 1'b1) n++;
      end
      checks += 2;
      if (n != 0) begin errors++; $display("FAIL stop_idle_strobes got %0d exp 0", n); end
      if (bus.ts_sent_cnt !== 12'd2) begin errors++; $display("FAIL stop_cnt_hold got %0d exp 2", bus.ts_sent_cnt); end
      bus.ts_update = 1'b1;
      bus.ts_stop = 1'b1;
      tick();
      bus.ts_update = 1'b0;
      bus.ts_stop = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.ts_valid === 1'b1) n++;
      end
      checks += 3;
      if (bus.ts_busy !== 1'b0) begin errors++; $display("FAIL updstop_busy got %0h exp 0", bus.ts_busy); end
      if (n != 0) begin errors++; $display("FAIL updstop_strobes got %0d exp 0", n); end
      if (bus.ts_sent_cnt !== 12'd2) begin errors++; $display("FAIL updstop_cnt got %0d exp 2", bus.ts_sent_cnt); end
   endtask
   task automatic test_lane_en();
      logic [7:0] exp_l2;
`ifdef TS_GEN_LANE_NUM_EN
      exp_l2 = 8'h02;
`else
      exp_l2 = 8'h00;
`endif
      start(8'h14, T0, 12'd1, 1'b1, 4'b0101);
      tick();
      checks += 5;
      if (bus.ts_valid !== 1'b1) begin errors++; $display("FAIL lane_valid got %0h exp 1", bus.ts_valid); end
      if (bus.ts_out[16 +: 8] !== 8'h00) begin errors++; $display("FAIL lane0_sym2 got %0h exp 0", bus.ts_out[16 +: 8]); end
      if (bus.ts_out[256+16 +: 8] !== exp_l2) begin errors++; $display("FAIL lane2_sym2 got %0h exp %0h", bus.ts_out[256+16 +: 8], exp_l2); end
      if (bus.ts_out[128 +: 128] !== '0 || bus.ts_out[384 +: 128] !== '0) begin errors++; $display("FAIL lane_off got %0h exp 0", bus.ts_out); end
      if (bus.ts_out !== exp_out(T0, 4'b0101)) begin errors++; $display("FAIL lane_out got %0h exp %0h", bus.ts_out, exp_out(T0, 4'b0101)); end
      stop();
      start(8'h15, TF, 12'd1, 1'b1, 4'b0101);
      tick();
      checks += 2;
      if (bus.ts_out[256+16 +: 8] !== 8'hF7) begin errors++; $display("FAIL lane_pad got %0h exp f7", bus.ts_out[256+16 +: 8]); end
      if (bus.ts_out !== exp_out(TF, 4'b0101)) begin errors++; $display("FAIL lane_pad_out got %0h exp %0h", bus.ts_out, exp_out(TF, 4'b0101)); end
      stop();
   endtask
   task automatic test_reset_stall();
      int n = 0;
      start(8'h33, T1, 12'd1, 1'b1, 4'hF);
      for (int k = 1; k <= 40; k++) begin
         bus.ts_tx_fifo_full = (k >= 2);
         tick();
      end
      checks++;
      if (bus.ts_busy !== 1'b1 || bus.ts_info_out !== 8'h33) begin errors++; $display("FAIL rst_pre busy %0h info %0h exp 1 33", bus.ts_busy, bus.ts_info_out); end
      rst_n = 1'b0;
      #1;
      test_reset();
      #2;
      rst_n = 1'b1;
      bus.ts_tx_fifo_full = 1'b0;
      for (int k = 0; k < 70; k++) begin
         tick();
         if (bus.ts_valid === 1'b1) n++;
      end
      checks += 2;
      if (n != 0) begin errors++; $display("FAIL rst_post_strobes got %0d exp 0", n); end
      if (bus.ts_busy !== 1'b0) begin errors++; $display("FAIL rst_post_busy got %0h exp 0", bus.ts_busy); end
   endtask
   initial begin
      bus.ts_info = '0; bus.ts = '0; bus.ts_tgt = '0; bus.ts_update = 1'b0; bus.ts_stop = 1'b0;
      bus.speed = 1'b0; bus.lane_en = '0; bus.ts_tx_fifo_full = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_gen1();
      test_stall();
      test_update_mid();
      test_stop();
      test_lane_en();
      test_reset_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
